// File: rtl/hicore_mem_arbt_pkg.sv
// Shared HiCore widths plus the source-id and grant-state encodings
// used by the fetch/LSU memory arbiter and its tag FIFO.
`ifndef HICORE_DEFINES
`define HICORE_DEFINES
`define HiCore_ADDR_SIZE 32
`define HiCore_REG_SIZE 32
`endif

package hicore_mem_arbt_pkg;

    typedef enum logic {
        SRC_IFU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int ADDR_W = `HiCore_ADDR_SIZE;
    localparam int REG_W  = `HiCore_REG_SIZE;
    localparam int MASK_W = `HiCore_REG_SIZE / 8;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    function automatic src_e rrPick(input logic ifuValid, input logic lsuValid,
                                    input src_e lastGrant);
        if (ifuValid && lsuValid)
            return (lastGrant == SRC_LSU) ? SRC_IFU : SRC_LSU;
        else if (ifuValid)
            return SRC_IFU;
        else
            return SRC_LSU;
    endfunction

endpackage

// File: rtl/hicore_tag_fifo.sv
// In-order tag FIFO remembering which requester owns each outstanding
// memory command, so responses can be steered back to it.
module hicore_tag_fifo #(
    parameter int DW = 1,
    parameter int DP = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [DW-1:0] mem_q [DP];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;

    // Explicit wrap keeps the FIFO correct for non power-of-two depths.
    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DP - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        wrPtr_d = push_i ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d = pop_i  ? nextPtr(rdPtr_q) : rdPtr_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DP; i++)
                mem_q[i] <= '0;
        end else if (push_i) begin
            mem_q[wrPtr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rdPtr_q];
    assign full_o  = (count_q == (AW + 1)'(DP));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/hicore_mem_arbt.sv
// Round-robin arbiter sharing one ICB memory port between fetch (ifu) and
// load/store (lsu), with an in-order tag FIFO routing responses back.
module hicore_mem_arbt
    import hicore_mem_arbt_pkg::*;
#(
    parameter int OSTD_DP  = 4,
    parameter int OSTD_LOG = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          ifu_icb_cmd_valid,
    output logic                          ifu_icb_cmd_ready,
    input  logic                          ifu_icb_cmd_read,
    input  logic [`HiCore_ADDR_SIZE-1:0]  ifu_icb_cmd_addr,
    input  logic [`HiCore_REG_SIZE-1:0]   ifu_icb_cmd_wdata,
    input  logic [`HiCore_REG_SIZE/8-1:0] ifu_icb_cmd_wmask,
    output logic                          ifu_icb_rsp_valid,
    input  logic                          ifu_icb_rsp_ready,
    output logic                          ifu_icb_rsp_err,
    output logic [`HiCore_REG_SIZE-1:0]   ifu_icb_rsp_rdata,

    input  logic                          lsu_icb_cmd_valid,
    output logic                          lsu_icb_cmd_ready,
    input  logic                          lsu_icb_cmd_read,
    input  logic [`HiCore_ADDR_SIZE-1:0]  lsu_icb_cmd_addr,
    input  logic [`HiCore_REG_SIZE-1:0]   lsu_icb_cmd_wdata,
    input  logic [`HiCore_REG_SIZE/8-1:0] lsu_icb_cmd_wmask,
    output logic                          lsu_icb_rsp_valid,
    input  logic                          lsu_icb_rsp_ready,
    output logic                          lsu_icb_rsp_err,
    output logic [`HiCore_REG_SIZE-1:0]   lsu_icb_rsp_rdata,

    output logic                          mem_icb_cmd_valid,
    input  logic                          mem_icb_cmd_ready,
    output logic                          mem_icb_cmd_read,
    output logic [`HiCore_ADDR_SIZE-1:0]  mem_icb_cmd_addr,
    output logic [`HiCore_REG_SIZE-1:0]   mem_icb_cmd_wdata,
    output logic [`HiCore_REG_SIZE/8-1:0] mem_icb_cmd_wmask,
    input  logic                          mem_icb_rsp_valid,
    output logic                          mem_icb_rsp_ready,
    input  logic                          mem_icb_rsp_err,
    input  logic [`HiCore_REG_SIZE-1:0]   mem_icb_rsp_rdata,

    output logic [OSTD_LOG:0]             ostd_cnt
);

    arb_state_e state_q;
    src_e       grant_q;
    src_e       lastGrant_q;

    src_e       winner;
    src_e       sel;
    logic       selValid;
    logic       slotAvail;
    logic       cmdFire;
    logic       rspFire;

    logic       fifoFull;
    logic       fifoEmpty;
    logic [0:0] headTag;
    src_e       headSrc;

    // While locked the stalled grant is held so the other side cannot steal it.
    always_comb begin
        winner   = rrPick(ifu_icb_cmd_valid, lsu_icb_cmd_valid, lastGrant_q);
        sel      = (state_q == ARB_LOCK) ? grant_q : winner;
        selValid = (sel == SRC_IFU) ? ifu_icb_cmd_valid : lsu_icb_cmd_valid;
    end

    assign slotAvail         = ~fifoFull;
    assign mem_icb_cmd_valid = selValid & slotAvail;
    assign mem_icb_cmd_read  = (sel == SRC_IFU) ? ifu_icb_cmd_read  : lsu_icb_cmd_read;
    assign mem_icb_cmd_addr  = (sel == SRC_IFU) ? ifu_icb_cmd_addr  : lsu_icb_cmd_addr;
    assign mem_icb_cmd_wdata = (sel == SRC_IFU) ? ifu_icb_cmd_wdata : lsu_icb_cmd_wdata;
    assign mem_icb_cmd_wmask = (sel == SRC_IFU) ? ifu_icb_cmd_wmask : lsu_icb_cmd_wmask;

    assign ifu_icb_cmd_ready = (sel == SRC_IFU) & selValid & slotAvail & mem_icb_cmd_ready;
    assign lsu_icb_cmd_ready = (sel == SRC_LSU) & selValid & slotAvail & mem_icb_cmd_ready;
    assign cmdFire           = mem_icb_cmd_valid & mem_icb_cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            grant_q     <= SRC_LSU;
            lastGrant_q <= SRC_LSU;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (mem_icb_cmd_valid && !mem_icb_cmd_ready) begin
                        state_q <= ARB_LOCK;
                        grant_q <= sel;
                    end
                end
                ARB_LOCK: begin
                    if (cmdFire || !selValid)
                        state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
            if (cmdFire)
                lastGrant_q <= sel;
        end
    end

    hicore_tag_fifo #(
        .DW (1),
        .DP (OSTD_DP),
        .AW (OSTD_LOG)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmdFire),
        .din_i   (sel),
        .pop_i   (rspFire),
        .dout_o  (headTag),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (ostd_cnt)
    );

    // Responses always belong to the oldest outstanding command.
    assign headSrc           = src_e'(headTag);
    assign ifu_icb_rsp_valid = ~fifoEmpty & (headSrc == SRC_IFU) & mem_icb_rsp_valid;
    assign lsu_icb_rsp_valid = ~fifoEmpty & (headSrc == SRC_LSU) & mem_icb_rsp_valid;
    assign mem_icb_rsp_ready = ~fifoEmpty &
                               ((headSrc == SRC_IFU) ? ifu_icb_rsp_ready : lsu_icb_rsp_ready);
    assign rspFire           = mem_icb_rsp_valid & mem_icb_rsp_ready;

    assign ifu_icb_rsp_err   = mem_icb_rsp_err;
    assign ifu_icb_rsp_rdata = mem_icb_rsp_rdata;
    assign lsu_icb_rsp_err   = mem_icb_rsp_err;
    assign lsu_icb_rsp_rdata = mem_icb_rsp_rdata;

    rspWithoutCmd: assert property (@(posedge clk) disable iff (!rst_n)
                                    mem_icb_rsp_valid |-> !fifoEmpty);

endmodule
